// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM addressing, one-word holding register with valid/ready.
// Optional misaligned-redirect flagging is enabled by defining FETCH_MISALIGN_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [31:0]       i_rom_data,
    input  logic              i_fetch_req,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [31:0]       o_instr,
    output logic [31:0]       o_instr_pc,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_misalign
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StValid
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misalign_q, misalign_d;

    logic [31:0] redirect_target;
    logic        redirect_misaligned;

`ifdef FETCH_MISALIGN_EN
    assign redirect_target     = i_redirect_pc;
    assign redirect_misaligned = |i_redirect_pc[1:0];
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^i_redirect_pc[1:0];
    assign redirect_target     = {i_redirect_pc[31:2], 2'b00};
    assign redirect_misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = misalign_q;

        // Redirect squashes whatever is in flight or held, regardless of state.
        if (i_redirect) begin
            pc_d       = redirect_target;
            state_d    = StIdle;
            misalign_d = redirect_misaligned;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_fetch_req && !misalign_q) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    instr_d    = i_rom_data;
                    instr_pc_d = pc_q;
                    state_d    = StValid;
                end
                StValid: begin
                    if (i_instr_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_rom_addr    = pc_q[ADDR_W-1:0];
    assign o_instr_valid = (state_q == StValid);
    assign o_instr       = instr_q;
    assign o_instr_pc    = instr_pc_q;
    assign o_misalign    = misalign_q;

    // A presented word must not change until it is accepted or squashed.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (o_instr_valid && !i_instr_ready && !i_redirect)
            |=> (o_instr_valid && $stable(o_instr) && $stable(o_instr_pc)));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, reset cases, then random traffic vs. a
// transaction-level model. Honours FETCH_MISALIGN_EN the same way as the design.
module tb_instr_fetch;

`ifdef FETCH_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] rom_addr;
    logic [31:0] rom_data;
    logic        fetch_req = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (14)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .i_fetch_req  (fetch_req),
        .o_instr_valid(instr_valid),
        .i_instr_ready(instr_ready),
        .o_instr      (instr),
        .o_instr_pc   (instr_pc),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_misalign   (misalign)
    );

    // Registered-read ROM, one word per 4 bytes.
    logic [31:0] rom [4096];
    always @(posedge clk) rom_data <= rom[rom_addr[13:2]];

    // Transaction-level model: cycles since the request was taken (0 none, 1 in ROM, 2 held).
    logic [31:0] m_pc;
    int          m_phase;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_phase = 0; m_instr = 32'h0; m_ipc = 32'h0; m_mis = 1'b0;
    endtask

    task automatic model_step(input logic req, input logic rdy, input logic redir,
                              input logic [31:0] rpc);
        if (redir) begin
            m_pc    = MIS ? rpc : (rpc & 32'hFFFF_FFFC);
            m_mis   = MIS && (rpc[1:0] != 2'b00);
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (req && !m_mis) m_phase = 1;
        end else if (m_phase == 1) begin
            m_instr = rom[m_pc[13:2]];
            m_ipc   = m_pc;
            m_phase = 2;
        end else if (rdy) begin
            m_pc    = m_pc + 32'd4;
            m_phase = 0;
        end
    endtask

    task automatic model_check();
        chk("valid", {31'h0, instr_valid}, {31'h0, m_phase == 2});
        chk("rom_addr", {18'h0, rom_addr}, {18'h0, m_pc[13:0]});
        chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
        if (m_phase == 2) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
        end
    endtask

    task automatic cycle(input logic req, input logic rdy, input logic redir,
                         input logic [31:0] rpc);
        fetch_req   = req;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        model_step(req, rdy, redir, rpc);
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        logic        req;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [13:0] e_addr;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic req, input logic rdy, input logic redir,
                                input logic [31:0] rpc, input logic e_valid,
                                input logic [31:0] e_ipc, input logic [13:0] e_addr,
                                input logic e_mis);
        vec_t v;
        v.req = req; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_valid = e_valid; v.e_ipc = e_ipc; v.e_addr = e_addr; v.e_mis = e_mis;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [13:0] mis_addr;
        logic [31:0] rpc;
        logic        req;
        logic        rdy;
        logic        redir;

        for (int i = 0; i < 4096; i++) rom[i] = $urandom;
        mis_addr = MIS ? 14'h2CA : 14'h2C8;

        // Back-to-back with req/ready held: valid every third cycle.
        add(1, 1, 0, 0, 0, 0, 14'h000, 0);
        add(1, 1, 0, 0, 1, 0, 14'h000, 0);
        add(1, 1, 0, 0, 0, 0, 14'h004, 0);
        add(1, 1, 0, 0, 0, 0, 14'h004, 0);
        add(1, 1, 0, 0, 1, 32'h4, 14'h004, 0);
        add(1, 1, 0, 0, 0, 0, 14'h008, 0);
        add(1, 1, 0, 0, 0, 0, 14'h008, 0);
        add(1, 1, 0, 0, 1, 32'h8, 14'h008, 0);
        // Consumer stalls for 5 cycles: word and pc held.
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 32'h8, 14'h008, 0);
        add(0, 1, 0, 0, 0, 0, 14'h00C, 0);
        // Redirect while the ROM read is in flight.
        add(1, 0, 0, 0, 0, 0, 14'h00C, 0);
        add(0, 0, 1, 32'h2C0, 0, 0, 14'h2C0, 0);
        add(0, 0, 0, 0, 0, 0, 14'h2C0, 0);
        add(1, 0, 0, 0, 0, 0, 14'h2C0, 0);
        add(0, 0, 0, 0, 1, 32'h2C0, 14'h2C0, 0);
        // Redirect beats a same-cycle accept.
        add(0, 1, 1, 32'h100, 0, 0, 14'h100, 0);
        add(1, 0, 0, 0, 0, 0, 14'h100, 0);
        add(0, 0, 0, 0, 1, 32'h100, 14'h100, 0);
        add(0, 1, 0, 0, 0, 0, 14'h104, 0);
        // PC wraps past the top of the address space.
        add(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 14'h3FFC, 0);
        add(1, 0, 0, 0, 0, 0, 14'h3FFC, 0);
        add(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 14'h3FFC, 0);
        add(0, 1, 0, 0, 0, 0, 14'h0000, 0);
        // Redirect with a request in IDLE drops the request.
        add(1, 0, 1, 32'h40, 0, 0, 14'h040, 0);
        add(0, 0, 0, 0, 0, 0, 14'h040, 0);
        add(0, 0, 0, 0, 0, 0, 14'h040, 0);
        // Misaligned redirect target.
        add(0, 0, 1, 32'h2CA, 0, 0, mis_addr, MIS);
        add(1, 0, 0, 0, 0, 0, mis_addr, MIS);
        add(1, 0, 0, 0, !MIS, 32'h2C8, mis_addr, MIS);
        add(0, 0, 1, 32'h2C8, 0, 0, 14'h2C8, 0);
        add(1, 0, 0, 0, 0, 0, 14'h2C8, 0);
        add(0, 0, 0, 0, 1, 32'h2C8, 14'h2C8, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_addr", {18'h0, rom_addr}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        rst_n = 1'b1;
        model_reset();

        foreach (vecs[i]) begin
            cycle(vecs[i].req, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d_addr", i), {18'h0, rom_addr}, {18'h0, vecs[i].e_addr});
            chk($sformatf("vec%0d_mis", i), {31'h0, misalign}, {31'h0, vecs[i].e_mis});
            if (vecs[i].e_valid) chk($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].e_ipc);
        end

        // Asynchronous reset while a word is held.
        cycle(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        chk("midrst_addr", {18'h0, rom_addr}, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_instr_pc", instr_pc, 32'h0);
        fetch_req = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            req   = ($urandom_range(0, 9) < 7);
            rdy   = $urandom_range(0, 1) == 1;
            redir = ($urandom_range(0, 19) == 0);
            rpc   = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, 4'($urandom)};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            cycle(req, rdy, redir, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
